mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline, sitting between the EX/MEM and MEM/WB pipeline registers.
- Drives the data-memory interface combinationally from EX/MEM inputs: address, store data, read/write strobes and byte enables.
- Formats load data by lane select plus sign/zero extension.
- Registers results into the MEM/WB pipeline register on the rising clock edge.

Parameters:
- None. Widths come from the shared constants: CONTROL_SIGNALS_WIDTH; bit/field macros CTRL_MEM_READ, CTRL_MEM_WRITE, CTRL_MEM_WIDTH, CTRL_MEM_UNSIGNED; codes MEM_BYTE, MEM_HALF, MEM_WORD.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low (0 = reset).
- ex_mem_pc  in  32  PC of the instruction in MEM.
- ex_mem_alu_result  in  32  effective address, or ALU result.
- ex_mem_rs2_data  in  32  store source data.
- ex_mem_rd_addr  in  5  destination register.
- ex_mem_control_signals  in  CONTROL_SIGNALS_WIDTH  control bundle.
- ex_mem_valid  in  1  instruction valid.
- dmem_addr  out  32  data-memory address.
- dmem_data_in  in  32  read data returned from memory in the same cycle (combinational).
- dmem_data_out  out  32  write data.
- dmem_read  out  1  read strobe.
- dmem_write  out  1  write strobe.
- dmem_byte_enable  out  4  write lane enables.
- mem_wb_pc  out  32  registered PC.
- mem_wb_alu_result  out  32  registered ALU result.
- mem_wb_mem_data  out  32  registered formatted load data.
- mem_wb_rd_addr  out  5  registered rd.
- mem_wb_control_signals  out  CONTROL_SIGNALS_WIDTH  registered control bundle.
- mem_wb_valid  out  1  registered valid.

Behaviour:
- Lane order is big-endian within the word. Address offset addr[1:0]=k selects byte data[31-8k -: 8]. Half at addr[1]=0 is data[31:16]; half at addr[1]=1 is data[15:0].
- Combinational memory side:
  - dmem_addr = ex_mem_alu_result, passed through unmasked.
  - dmem_read = ex_mem_valid & CTRL_MEM_READ.
  - dmem_write = ex_mem_valid & CTRL_MEM_WRITE.
- Store data is lane-replicated:
  - byte: {4{rs2[7:0]}}
  - half: {2{rs2[15:0]}}
  - word: rs2
- Byte enables apply to stores only and are 0000 when not a valid store.
  - Bit 3 maps to data[31:24].
  - byte: one-hot 1000 >> addr[1:0]
  - half: 1100 if addr[1]=0, else 0011
  - word: 1111
- Misaligned accesses get no trap or alignment check.
  - Half accesses use addr[1] only; addr[0] is ignored.
  - Word accesses ignore addr[1:0].
- Load formatting: select the lane, then sign-extend, or zero-extend when CTRL_MEM_UNSIGNED=1. Word loads pass through unchanged.
- When the instruction is not a valid load, the formatted data is 0.
- MEM/WB register:
  - Captures on every rising edge; there is no stall or flush input.
  - pc, alu_result, rd_addr, control_signals and valid pass straight through.
  - mem_data captures the formatted load data.
  - Latency: 1 cycle from EX/MEM inputs to mem_wb_* outputs.
- Reset (reset=0 at a rising edge): every mem_wb_* output is cleared to 0.
  - The dmem_* outputs stay combinational during reset, still gated by ex_mem_valid.
  - A reset asserted mid-operation discards the in-flight MEM/WB contents.
- If both read and write are set, both strobes assert; upstream decode guarantees this never happens.

Decomposition:
- Shared constants include (constants.v):
  - CONTROL_SIGNALS_WIDTH and the CTRL_* bit/field positions.
  - Width codes MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10, with CTRL_MEM_WIDTH a 2-bit field.
- One natural sub-module, load_formatter: a combinational lane-select plus extend block taking (data, addr[1:0], width, unsigned) and producing 32-bit data.
- Store replication, byte enables and the MEM/WB register stay in mem_stage.

Test Plan:
- LBU: addr 0x0, dmem_data_in 0xFF000000, width BYTE, unsigned=1, read=1 -> mem_wb_mem_data 0x000000FF after one edge.
- LB: addr 0x0, dmem_data_in 0x80000000, unsigned=0 -> 0xFFFFFF80.
- LHU/LH at addr 0x2 (upper-offset half = data[15:0]):
  - data 0x0000FFFF, unsigned=1 -> 0x0000FFFF.
  - data 0x00008000, unsigned=0 -> 0xFFFF8000.
- LW: addr 0x0, data 0xCAFEBABE -> 0xCAFEBABE; mem_wb_rd_addr, pc and valid match inputs one cycle later.
- SW: addr 0x10000000, rs2 0x12345678, write=1, width WORD -> within 1 ns (combinational) dmem_addr 0x10000000, dmem_data_out 0x12345678, dmem_write 1, byte_enable 1111.
- SB at addr 0x3 with rs2 0xAB -> data_out 0xABABABAB, byte_enable 0001.
- Any access with ex_mem_valid=0 -> strobes 0, byte_enable 0000.
- reset=0 at an edge -> all mem_wb_* outputs 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: control-bundle layout, access width codes,
// and the MEM/WB register record.
package mem_stage_pkg;
    localparam int CONTROL_SIGNALS_WIDTH = 8;

    // Control bundle bit/field positions (CTRL_MEM_WIDTH is the LSB of a 2-bit field)
    localparam int CTRL_MEM_READ     = 0;
    localparam int CTRL_MEM_WRITE    = 1;
    localparam int CTRL_MEM_WIDTH    = 2;
    localparam int CTRL_MEM_UNSIGNED = 4;
    localparam int CTRL_REG_WRITE    = 5;
    localparam int CTRL_MEM_TO_REG   = 6;
    localparam int CTRL_BRANCH       = 7;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef struct packed {
        logic [31:0]                      pc;
        logic [31:0]                      alu_result;
        logic [31:0]                      mem_data;
        logic [4:0]                       rd_addr;
        logic [CONTROL_SIGNALS_WIDTH-1:0] control_signals;
        logic                             valid;
    } mem_wb_t;

    function automatic logic [1:0] ctrl_width(input logic [CONTROL_SIGNALS_WIDTH-1:0] ctrl);
        return ctrl[CTRL_MEM_WIDTH +: 2];
    endfunction
endpackage

// File: rtl/mem_stage_load_formatter.sv
// Load lane select plus sign/zero extension. Lanes are big-endian within the word:
// offset 0 is data[31:24], and the half at addr[1]=0 is data[31:16].
module load_formatter
    import mem_stage_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr,
    input  logic [1:0]  width,
    input  logic        is_unsigned,
    output logic [31:0] result
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = data[31 - 8*addr -: 8];
        half_lane = addr[1] ? data[15:0] : data[31:16];
        case (width)
            MEM_BYTE: result = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            MEM_HALF: result = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default:  result = data;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM stage: drives the data-memory interface combinationally from EX/MEM
// and registers the formatted load result into MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [31:0]                      ex_mem_pc,
    input  logic [31:0]                      ex_mem_alu_result,
    input  logic [31:0]                      ex_mem_rs2_data,
    input  logic [4:0]                       ex_mem_rd_addr,
    input  logic [CONTROL_SIGNALS_WIDTH-1:0] ex_mem_control_signals,
    input  logic                             ex_mem_valid,
    output logic [31:0]                      dmem_addr,
    input  logic [31:0]                      dmem_data_in,
    output logic [31:0]                      dmem_data_out,
    output logic                             dmem_read,
    output logic                             dmem_write,
    output logic [3:0]                       dmem_byte_enable,
    output logic [31:0]                      mem_wb_pc,
    output logic [31:0]                      mem_wb_alu_result,
    output logic [31:0]                      mem_wb_mem_data,
    output logic [4:0]                       mem_wb_rd_addr,
    output logic [CONTROL_SIGNALS_WIDTH-1:0] mem_wb_control_signals,
    output logic                             mem_wb_valid
);
    logic [1:0]  width;
    logic [31:0] fmt_data;
    logic [31:0] load_data;
    mem_wb_t     wb_q;

    assign width      = ctrl_width(ex_mem_control_signals);
    assign dmem_addr  = ex_mem_alu_result;
    assign dmem_read  = ex_mem_valid & ex_mem_control_signals[CTRL_MEM_READ];
    assign dmem_write = ex_mem_valid & ex_mem_control_signals[CTRL_MEM_WRITE];

    // Store data is replicated across lanes so memory only has to honour the enables.
    always_comb begin
        dmem_data_out    = ex_mem_rs2_data;
        dmem_byte_enable = 4'b1111;
        case (width)
            MEM_BYTE: begin
                dmem_data_out    = {4{ex_mem_rs2_data[7:0]}};
                dmem_byte_enable = 4'b1000 >> ex_mem_alu_result[1:0];
            end
            MEM_HALF: begin
                dmem_data_out    = {2{ex_mem_rs2_data[15:0]}};
                dmem_byte_enable = ex_mem_alu_result[1] ? 4'b0011 : 4'b1100;
            end
            default: ;
        endcase
        if (!dmem_write)
            dmem_byte_enable = 4'b0000;
    end

    load_formatter u_load_formatter (
        .data        (dmem_data_in),
        .addr        (ex_mem_alu_result[1:0]),
        .width       (width),
        .is_unsigned (ex_mem_control_signals[CTRL_MEM_UNSIGNED]),
        .result      (fmt_data)
    );

    assign load_data = dmem_read ? fmt_data : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_q <= '0;
        end else begin
            wb_q.pc              <= ex_mem_pc;
            wb_q.alu_result      <= ex_mem_alu_result;
            wb_q.mem_data        <= load_data;
            wb_q.rd_addr         <= ex_mem_rd_addr;
            wb_q.control_signals <= ex_mem_control_signals;
            wb_q.valid           <= ex_mem_valid;
        end
    end

    assign mem_wb_pc              = wb_q.pc;
    assign mem_wb_alu_result      = wb_q.alu_result;
    assign mem_wb_mem_data        = wb_q.mem_data;
    assign mem_wb_rd_addr         = wb_q.rd_addr;
    assign mem_wb_control_signals = wb_q.control_signals;
    assign mem_wb_valid           = wb_q.valid;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset sequences, and random traffic
// checked against an arithmetic model of load/store lane rules.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ex_mem_pc, ex_mem_alu_result, ex_mem_rs2_data;
    logic [4:0]  ex_mem_rd_addr;
    logic [CONTROL_SIGNALS_WIDTH-1:0] ex_mem_control_signals;
    logic        ex_mem_valid;
    logic [31:0] dmem_addr, dmem_data_in, dmem_data_out;
    logic        dmem_read, dmem_write;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] mem_wb_pc, mem_wb_alu_result, mem_wb_mem_data;
    logic [4:0]  mem_wb_rd_addr;
    logic [CONTROL_SIGNALS_WIDTH-1:0] mem_wb_control_signals;
    logic        mem_wb_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .ex_mem_pc(ex_mem_pc), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_rs2_data(ex_mem_rs2_data), .ex_mem_rd_addr(ex_mem_rd_addr),
        .ex_mem_control_signals(ex_mem_control_signals), .ex_mem_valid(ex_mem_valid),
        .dmem_addr(dmem_addr), .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
        .mem_wb_pc(mem_wb_pc), .mem_wb_alu_result(mem_wb_alu_result),
        .mem_wb_mem_data(mem_wb_mem_data), .mem_wb_rd_addr(mem_wb_rd_addr),
        .mem_wb_control_signals(mem_wb_control_signals), .mem_wb_valid(mem_wb_valid)
    );

    typedef struct {
        logic [31:0] addr, rs2, din;
        logic        rd, wr, uns, valid;
        logic [1:0]  width;
        logic [31:0] exp_data, exp_dout;
        logic [3:0]  exp_be;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [CONTROL_SIGNALS_WIDTH-1:0] mk_ctrl(
        input logic rd, input logic wr, input logic [1:0] w, input logic uns, input logic [2:0] extra);
        logic [CONTROL_SIGNALS_WIDTH-1:0] c;
        c = '0;
        c[CTRL_MEM_READ]          = rd;
        c[CTRL_MEM_WRITE]         = wr;
        c[CTRL_MEM_WIDTH +: 2]    = w;
        c[CTRL_MEM_UNSIGNED]      = uns;
        c[CTRL_REG_WRITE]         = extra[0];
        c[CTRL_MEM_TO_REG]        = extra[1];
        c[CTRL_BRANCH]            = extra[2];
        return c;
    endfunction

    // Reference model: lanes counted from the most significant byte, extension by arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] din, input logic [31:0] addr,
                                               input logic [1:0] w, input logic uns);
        longint v;
        int k;
        k = int'(addr % 4);
        if (w == MEM_BYTE) begin
            v = (longint'(din) >> (8 * (3 - k))) % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (w == MEM_HALF) begin
            v = (k >= 2) ? longint'(din) % 65536 : longint'(din) / 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(din);
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] rs2, input logic [1:0] w);
        logic [31:0] b, h;
        b = rs2 % 256;
        h = rs2 % 65536;
        if (w == MEM_BYTE) return b * 32'h01010101;
        if (w == MEM_HALF) return h * 32'h00010001;
        return rs2;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] w);
        int k;
        k = int'(addr % 4);
        if (w == MEM_BYTE) return 4'(1 << (3 - k));
        if (w == MEM_HALF) return (k >= 2) ? 4'd3 : 4'd12;
        return 4'd15;
    endfunction

    // Drive one instruction shortly after a posedge, check the memory side, then MEM/WB.
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [CONTROL_SIGNALS_WIDTH-1:0] ctrl;
        pc      = $urandom;
        rd_addr = 5'($urandom_range(0, 31));
        ctrl    = mk_ctrl(v.rd, v.wr, v.width, v.uns, 3'($urandom_range(0, 7)));
        ex_mem_pc              = pc;
        ex_mem_alu_result      = v.addr;
        ex_mem_rs2_data        = v.rs2;
        ex_mem_rd_addr         = rd_addr;
        ex_mem_control_signals = ctrl;
        ex_mem_valid           = v.valid;
        dmem_data_in           = v.din;
        #1;
        check({tag, " dmem_addr"}, dmem_addr, v.addr);
        check({tag, " dmem_read"}, 32'(dmem_read), 32'(v.valid & v.rd));
        check({tag, " dmem_write"}, 32'(dmem_write), 32'(v.valid & v.wr));
        check({tag, " byte_enable"}, 32'(dmem_byte_enable), 32'(v.exp_be));
        check({tag, " data_out"}, dmem_data_out, v.exp_dout);
        @(posedge clk); #1;
        check({tag, " wb_mem_data"}, mem_wb_mem_data, v.exp_data);
        check({tag, " wb_pc"}, mem_wb_pc, pc);
        check({tag, " wb_alu"}, mem_wb_alu_result, v.addr);
        check({tag, " wb_rd"}, 32'(mem_wb_rd_addr), 32'(rd_addr));
        check({tag, " wb_ctrl"}, 32'(mem_wb_control_signals), 32'(ctrl));
        check({tag, " wb_valid"}, 32'(mem_wb_valid), 32'(v.valid));
    endtask

    function automatic vec_t mkv(input logic [31:0] addr, rs2, din, input logic rd, wr,
                                 input logic [1:0] w, input logic uns, valid,
                                 input logic [31:0] ed, edo, input logic [3:0] ebe);
        vec_t v;
        v.addr = addr; v.rs2 = rs2; v.din = din; v.rd = rd; v.wr = wr; v.width = w;
        v.uns = uns; v.valid = valid; v.exp_data = ed; v.exp_dout = edo; v.exp_be = ebe;
        return v;
    endfunction

    task automatic check_wb_zero(input string tag);
        check({tag, " wb_pc"}, mem_wb_pc, 32'h0);
        check({tag, " wb_alu"}, mem_wb_alu_result, 32'h0);
        check({tag, " wb_mem_data"}, mem_wb_mem_data, 32'h0);
        check({tag, " wb_rd"}, 32'(mem_wb_rd_addr), 32'h0);
        check({tag, " wb_ctrl"}, 32'(mem_wb_control_signals), 32'h0);
        check({tag, " wb_valid"}, 32'(mem_wb_valid), 32'h0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;

        tbl.push_back(mkv(32'h0, 32'h0, 32'hFF000000, 1, 0, MEM_BYTE, 1, 1, 32'h000000FF, 32'h0, 4'b0000));
        tbl.push_back(mkv(32'h0, 32'h0, 32'h80000000, 1, 0, MEM_BYTE, 0, 1, 32'hFFFFFF80, 32'h0, 4'b0000));
        tbl.push_back(mkv(32'h2, 32'h0, 32'h0000FFFF, 1, 0, MEM_HALF, 1, 1, 32'h0000FFFF, 32'h0, 4'b0000));
        tbl.push_back(mkv(32'h2, 32'h0, 32'h00008000, 1, 0, MEM_HALF, 0, 1, 32'hFFFF8000, 32'h0, 4'b0000));
        tbl.push_back(mkv(32'h0, 32'h0, 32'hCAFEBABE, 1, 0, MEM_WORD, 0, 1, 32'hCAFEBABE, 32'h0, 4'b0000));
        tbl.push_back(mkv(32'h3, 32'h0, 32'h123456F1, 1, 0, MEM_BYTE, 0, 1, 32'hFFFFFFF1, 32'h0, 4'b0000));
        tbl.push_back(mkv(32'h1, 32'h0, 32'h12805678, 1, 0, MEM_HALF, 0, 1, 32'h00001280, 32'h0, 4'b0000));
        tbl.push_back(mkv(32'h10000000, 32'h12345678, 32'h0, 0, 1, MEM_WORD, 0, 1, 32'h0, 32'h12345678, 4'b1111));
        tbl.push_back(mkv(32'h3, 32'h000000AB, 32'h0, 0, 1, MEM_BYTE, 0, 1, 32'h0, 32'hABABABAB, 4'b0001));
        tbl.push_back(mkv(32'h1, 32'h000000CD, 32'h0, 0, 1, MEM_BYTE, 0, 1, 32'h0, 32'hCDCDCDCD, 4'b0100));
        tbl.push_back(mkv(32'h3, 32'h9999BEEF, 32'h0, 0, 1, MEM_HALF, 0, 1, 32'h0, 32'hBEEFBEEF, 4'b0011));
        tbl.push_back(mkv(32'h7, 32'hDEADBEEF, 32'h0, 0, 1, MEM_WORD, 0, 1, 32'h0, 32'hDEADBEEF, 4'b1111));
        tbl.push_back(mkv(32'h0, 32'h000000AB, 32'hFF000000, 1, 1, MEM_BYTE, 1, 0, 32'h0, 32'hABABABAB, 4'b0000));

        reset = 1'b0;
        ex_mem_pc = 32'h1234; ex_mem_alu_result = 32'h0; ex_mem_rs2_data = 32'h0;
        ex_mem_rd_addr = 5'd7; ex_mem_control_signals = mk_ctrl(1, 0, MEM_WORD, 0, 3'b001);
        ex_mem_valid = 1'b1; dmem_data_in = 32'hFFFFFFFF;
        @(posedge clk); #1;
        check_wb_zero("reset");
        check("reset comb read", 32'(dmem_read), 32'h1);
        reset = 1'b1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset mid-stream discards the in-flight MEM/WB contents.
        apply(mkv(32'h0, 32'h0, 32'hCAFEBABE, 1, 0, MEM_WORD, 0, 1, 32'hCAFEBABE, 32'h0, 4'b0000), "pre_rst");
        ex_mem_control_signals = mk_ctrl(0, 1, MEM_WORD, 0, 3'b000);
        ex_mem_valid = 1'b1;
        reset = 1'b0;
        #1;
        check("midrst comb write", 32'(dmem_write), 32'h1);
        check("midrst comb be", 32'(dmem_byte_enable), 32'hF);
        @(posedge clk); #1;
        check_wb_zero("midrst");
        reset = 1'b1;

        for (int i = 0; i < 300; i++) begin
            v.addr  = $urandom;
            v.rs2   = $urandom;
            v.din   = $urandom;
            v.rd    = 1'($urandom_range(0, 1));
            v.wr    = 1'($urandom_range(0, 1));
            v.width = 2'($urandom_range(0, 2));
            v.uns   = 1'($urandom_range(0, 1));
            v.valid = ($urandom_range(0, 3) != 0);
            v.exp_data = (v.valid && v.rd) ? model_load(v.din, v.addr, v.width, v.uns) : 32'h0;
            v.exp_dout = model_store(v.rs2, v.width);
            v.exp_be   = (v.valid && v.wr) ? model_be(v.addr, v.width) : 4'b0000;
            apply(v, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
